// File: rtl/axi_master_bridge.sv
// axi_master_bridge: single-outstanding AXI4 master for a CPU memory port.
// Optional response/ID checking on resp_err is built when AXI_MASTER_RESP_CHECK_EN is defined.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_BURST_BITS
`define AXI_BURST_BITS 2
`endif
`ifndef AXI_RESP_BITS
`define AXI_RESP_BITS 2
`endif

module axi_master_bridge #(
  parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = '0
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic                        req_valid,
  input  logic                        req_we,
  input  logic [31:0]                 req_addr,
  input  logic [31:0]                 req_wdata,
  input  logic [3:0]                  req_wstrb,
  output logic                        busy,
  output logic                        resp_valid,
  output logic [31:0]                 resp_rdata,
  output logic                        resp_err,
  output logic [`AXI_ID_BITS-1:0]     ARID,
  output logic [`AXI_ADDR_BITS-1:0]   ARADDR,
  output logic [`AXI_LEN_BITS-1:0]    ARLEN,
  output logic [`AXI_SIZE_BITS-1:0]   ARSIZE,
  output logic [`AXI_BURST_BITS-1:0]  ARBURST,
  output logic                        ARVALID,
  input  logic                        ARREADY,
  input  logic [`AXI_ID_BITS-1:0]     RID,
  input  logic [`AXI_DATA_BITS-1:0]   RDATA,
  input  logic [`AXI_RESP_BITS-1:0]   RRESP,
  input  logic                        RLAST,
  input  logic                        RVALID,
  output logic                        RREADY,
  output logic [`AXI_ID_BITS-1:0]     AWID,
  output logic [`AXI_ADDR_BITS-1:0]   AWADDR,
  output logic [`AXI_LEN_BITS-1:0]    AWLEN,
  output logic [`AXI_SIZE_BITS-1:0]   AWSIZE,
  output logic [`AXI_BURST_BITS-1:0]  AWBURST,
  output logic                        AWVALID,
  input  logic                        AWREADY,
  output logic [`AXI_DATA_BITS-1:0]   WDATA,
  output logic [`AXI_STRB_BITS-1:0]   WSTRB,
  output logic                        WLAST,
  output logic                        WVALID,
  input  logic                        WREADY,
  input  logic [`AXI_ID_BITS-1:0]     BID,
  input  logic [`AXI_RESP_BITS-1:0]   BRESP,
  input  logic                        BVALID,
  output logic                        BREADY
);
  typedef enum logic [2:0] {IDLE, RADDR, RDATA_S, WADDR, WRESP, RESP} state_t;
  state_t state;
  logic aw_done, w_done, r_got;
  logic aw_hs, w_hs, aw_n, w_n, r_hs, b_hs;
  assign ARID    = MASTER_ID;
  assign AWID    = MASTER_ID;
  assign ARLEN   = '0;
  assign AWLEN   = '0;
  assign ARSIZE  = 3'b010;
  assign AWSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign AWBURST = 2'b01;
  assign WLAST   = 1'b1;
  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign aw_n  = aw_done | aw_hs;
  assign w_n   = w_done | w_hs;
  assign r_hs  = (state == RDATA_S) & RVALID & RREADY;
  assign b_hs  = (state == WRESP) & BVALID & BREADY;
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state      <= IDLE;
      ARVALID    <= 1'b0;
      RREADY     <= 1'b0;
      AWVALID    <= 1'b0;
      WVALID     <= 1'b0;
      BREADY     <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      r_got      <= 1'b0;
      ARADDR     <= '0;
      AWADDR     <= '0;
      WDATA      <= '0;
      WSTRB      <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          busy <= 1'b1;
          // An all-zero strobe carries no write, so it is issued as a read
          if (req_we && |req_wstrb) begin
            AWADDR  <= req_addr;
            WDATA   <= req_wdata;
            WSTRB   <= req_wstrb;
            AWVALID <= 1'b1;
            WVALID  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WADDR;
          end else begin
            ARADDR  <= req_addr;
            ARVALID <= 1'b1;
            state   <= RADDR;
          end
        end
        RADDR: if (ARREADY) begin
          ARVALID <= 1'b0;
          RREADY  <= 1'b1;
          r_got   <= 1'b0;
          state   <= RDATA_S;
        end
        RDATA_S: if (r_hs) begin
          r_got <= 1'b1;
          if (!r_got) resp_rdata <= RDATA;
          if (RLAST) begin
            RREADY     <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WADDR: begin
          if (aw_hs) AWVALID <= 1'b0;
          if (w_hs) WVALID <= 1'b0;
          aw_done <= aw_n;
          w_done  <= w_n;
          if (aw_n && w_n) begin
            BREADY <= 1'b1;
            state  <= WRESP;
          end
        end
        WRESP: if (b_hs) begin
          BREADY     <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef AXI_MASTER_RESP_CHECK_EN
  logic r_err, rd_bad, wr_bad;
  assign rd_bad = (RRESP != 2'b00) | (RID != MASTER_ID);
  assign wr_bad = (BRESP != 2'b00) | (BID != MASTER_ID);
  // Read status comes from the first beat, the same beat whose data is returned
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_err    <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      resp_err <= 1'b0;
      if (r_hs && !r_got) r_err <= rd_bad;
      if (r_hs && RLAST) resp_err <= r_got ? r_err : rd_bad;
      if (b_hs) resp_err <= wr_bad;
    end
  end
`else
  logic unused_status;
  assign unused_status = ^{RID, RRESP, BID, BRESP};
  assign resp_err = 1'b0;
`endif
endmodule

// File: tb/tb_axi_master_bridge.sv
// tb_axi_master_bridge: vector-table bench with a cycle-level AXI slave model and a
// response scoreboard for axi_master_bridge.
`timescale 1ns/1ps
module tb_axi_master_bridge;
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;
  logic req_valid, req_we, busy, resp_valid, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [3:0] req_wstrb;
  logic [3:0] ARID, AWID, RID, BID, ARLEN, AWLEN;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
  logic [2:0] ARSIZE, AWSIZE;
  logic [1:0] ARBURST, AWBURST, RRESP, BRESP;
  logic [3:0] WSTRB;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY, AWVALID, AWREADY;
  logic WLAST, WVALID, WREADY, BVALID, BREADY;

  axi_master_bridge #(.MASTER_ID(4'd0)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          ard, rd, awd, wd, bd, beats;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [3:0]  id;
    int          lat;
  } vec_t;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  vec_t tbl[12];
  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] last_rdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic exp_err(input vec_t v);
`ifdef AXI_MASTER_RESP_CHECK_EN
    return (v.resp != 2'b00) || (v.id != 4'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle_slave();
    ARREADY = 0; RVALID = 0; RLAST = 0; RDATA = 0; RRESP = 0; RID = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; BID = 0;
  endtask

  task automatic run(input vec_t v);
    exp_t e, got;
    logic rd;
    int ar_c, aw_c, w_c, beats, arv, awv, wv, wbeats, busy_lo, c;
    bit done, bdone;
    rd = !(v.we && v.strb != 4'b0);
    ar_c = -1; aw_c = -1; w_c = -1; beats = 0; arv = 0; awv = 0; wv = 0;
    wbeats = 0; busy_lo = 0; done = 0; bdone = 0; c = 0;
    e.rdata = rd ? v.rdata : last_rdata;
    e.err = exp_err(v);
    e.lat = v.lat;
    sb.push_back(e);
    @(negedge ACLK);
    req_valid = 1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.strb;
    while (c < 60 && !done) begin
      c++;
      @(negedge ACLK);
      if (ARVALID) arv++;
      if (AWVALID) awv++;
      if (WVALID) wv++;
      if (!busy) busy_lo++;
      ARREADY = ARVALID && c >= 1 + v.ard;
      AWREADY = AWVALID && c >= 1 + v.awd;
      WREADY  = WVALID && c >= 1 + v.wd;
      RVALID  = ar_c >= 0 && beats < v.beats && c >= ar_c + 1 + v.rd;
      RDATA   = beats == 0 ? v.rdata : ~v.rdata;
      RRESP   = beats == 0 ? v.resp : 2'b00;
      RID     = v.id;
      RLAST   = beats == v.beats - 1;
      BVALID  = aw_c >= 0 && w_c >= 0 && !bdone && c >= (aw_c > w_c ? aw_c : w_c) + 1 + v.bd;
      BRESP   = v.resp;
      BID     = v.id;
      if (ARVALID && ARREADY) begin
        ar_c = c;
        chk("araddr", ARADDR, v.addr);
        chk("ar_len_size_burst", {ARID, ARLEN, ARSIZE, ARBURST}, {4'd0, 4'd0, 3'd2, 2'd1});
      end
      if (AWVALID && AWREADY) begin
        aw_c = c;
        chk("awaddr", AWADDR, v.addr);
        chk("aw_len_size_burst", {AWID, AWLEN, AWSIZE, AWBURST}, {4'd0, 4'd0, 3'd2, 2'd1});
      end
      if (WVALID && WREADY) begin
        w_c = c;
        wbeats++;
        chk("w_data_strb_last", {WDATA, WSTRB, WLAST}, {v.wdata, v.strb, 1'b1});
      end
      if (RVALID && RREADY) beats++;
      if (BVALID && BREADY) bdone = 1;
      if (resp_valid) begin
        done = 1;
        req_valid = 0;
        idle_slave();
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin
          got = sb.pop_front();
          chk("resp_lat", c, got.lat);
          chk("resp_rdata", resp_rdata, got.rdata);
          chk("resp_err", resp_err, got.err);
          if (rd) last_rdata = v.rdata;
        end
      end
    end
    if (!done) begin
      chk("timeout", 0, 1);
      void'(sb.pop_front());
      req_valid = 0;
      idle_slave();
      ARESETn = 0;
      @(negedge ACLK);
      ARESETn = 1;
      last_rdata = 0;
    end else begin
      chk("arvalid_cycles", arv, rd ? v.ard + 1 : 0);
      chk("awvalid_cycles", awv, rd ? 0 : v.awd + 1);
      chk("wvalid_cycles", wv, rd ? 0 : v.wd + 1);
      chk("w_beats", wbeats, rd ? 0 : 1);
      chk("busy_during", busy_lo, 0);
      @(negedge ACLK);
      chk("resp_pulse_end", {resp_valid, resp_err, busy}, 3'b000);
    end
  endtask

  initial begin
    //          we addr          wdata          strb    ard rd awd wd bd beats rdata          resp   id    lat
    tbl[0]  = '{0, 32'h10,       32'h0,         4'h0,   0,  0, 0,  0, 0, 1,    32'hDEADBEEF,  2'b00, 4'h0, 3};
    tbl[1]  = '{0, 32'h14,       32'h0,         4'h0,   3,  0, 0,  0, 0, 1,    32'hCAFEF00D,  2'b00, 4'h0, 6};
    tbl[2]  = '{1, 32'h20,       32'h12345678,  4'h3,   0,  0, 0,  3, 0, 1,    32'h0,         2'b00, 4'h0, 6};
    tbl[3]  = '{1, 32'h24,       32'hA5A5A5A5,  4'hF,   0,  0, 0,  0, 0, 1,    32'h0,         2'b00, 4'h0, 3};
    tbl[4]  = '{1, 32'h28,       32'h0BADC0DE,  4'h8,   0,  0, 2,  0, 2, 1,    32'h0,         2'b00, 4'h0, 7};
    tbl[5]  = '{0, 32'h100,      32'h0,         4'h0,   1,  2, 0,  0, 0, 1,    32'h11223344,  2'b00, 4'h0, 6};
    tbl[6]  = '{1, 32'h104,      32'hFFFFFFFF,  4'h0,   0,  0, 0,  0, 0, 1,    32'h55667788,  2'b00, 4'h0, 3};
    tbl[7]  = '{0, 32'h108,      32'h0,         4'h0,   0,  0, 0,  0, 0, 3,    32'h99AABBCC,  2'b00, 4'h0, 5};
    tbl[8]  = '{1, 32'h30,       32'hFEEDFACE,  4'hF,   0,  0, 0,  0, 0, 1,    32'h0,         2'b10, 4'h0, 3};
    tbl[9]  = '{0, 32'h34,       32'h0,         4'h0,   0,  0, 0,  0, 0, 1,    32'h13579BDF,  2'b10, 4'h0, 3};
    tbl[10] = '{0, 32'h38,       32'h0,         4'h0,   0,  1, 0,  0, 0, 1,    32'h2468ACE0,  2'b00, 4'h3, 4};
    tbl[11] = '{1, 32'h3C,       32'h0F0F0F0F,  4'h1,   0,  0, 1,  1, 0, 1,    32'h0,         2'b00, 4'h5, 4};
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    idle_slave();
    ARESETn = 0;
    repeat (2) @(negedge ACLK);
    chk("reset_valids", {ARVALID, RREADY, AWVALID, WVALID, BREADY}, 5'b0);
    chk("reset_core", {busy, resp_valid, resp_err}, 3'b0);
    chk("reset_rdata", resp_rdata, 32'h0);
    ARESETn = 1;
    foreach (tbl[i]) run(tbl[i]);
    // Abort a read while it waits in the data phase
    begin
      int c;
      bit seen;
      int pulses;
      c = 0; seen = 0; pulses = 0;
      @(negedge ACLK);
      req_valid = 1; req_we = 0; req_addr = 32'h200; req_wstrb = 0;
      while (c < 10 && !seen) begin
        c++;
        @(negedge ACLK);
        ARREADY = ARVALID;
        seen = RREADY;
      end
      chk("abort_reached_rdata", seen, 1);
      req_valid = 0;
      idle_slave();
      ARESETn = 0;
      @(negedge ACLK);
      chk("abort_valids", {ARVALID, RREADY, AWVALID, WVALID, BREADY}, 5'b0);
      chk("abort_core", {busy, resp_valid}, 2'b0);
      ARESETn = 1;
      repeat (4) begin
        @(negedge ACLK);
        if (resp_valid) pulses++;
      end
      chk("abort_no_resp", pulses, 0);
      last_rdata = 0;
      chk("abort_rdata_cleared", resp_rdata, 32'h0);
    end
    run(tbl[0]);
    run(tbl[8]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
